// File: rtl/decrypt_round_engine_if.sv
// Block-level bus of the AES inverse-cipher engine: ciphertext handshake,
// round-key store lookup and plaintext handshake. AES256_EN adds key256.
interface decrypt_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES256_EN
  logic         key256;

  // Upstream / key store / downstream side
  modport master (
    output in_valid, in_data, round_key, out_ready, key256,
    input  in_ready, key_idx, out_valid, out_data
  );

  // Engine side
  modport slave (
    input  in_valid, in_data, round_key, out_ready, key256,
    output in_ready, key_idx, out_valid, out_data
  );
`else
  // Upstream / key store / downstream side
  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, key_idx, out_valid, out_data
  );

  // Engine side
  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, key_idx, out_valid, out_data
  );
`endif
endinterface

// File: rtl/decrypt_round_engine.sv
// Iterative AES inverse cipher, one round per clock. Initial AddRoundKey on
// accept, Nr-1 full inverse rounds, one final inverse round, then the result
// is held until the downstream takes it. Round keys come combinationally from
// an external store addressed by key_idx.
// Optional feature macro: AES256_EN (adds key256 port, Nr = 14 when set).
module decrypt_round_engine #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 128
) (
  input logic                   clk,
  input logic                   rst,  // active-low, asynchronous
  decrypt_round_engine_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StFinal = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [2047:0] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return InvSboxTbl[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the top byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [1:0]            fsm_q, fsm_d;
  logic [3:0]            rnd_q, rnd_d;
  logic [DATA_WIDTH-1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic [3:0]            nr_in;
  logic [KEY_WIDTH-1:0]  rk;
  logic [DATA_WIDTH-1:0] shifted, subbed, keyed, mixed;

  // Nr for a block about to be accepted; afterwards the counter carries it
`ifdef AES256_EN
  assign nr_in = bus.key256 ? 4'd14 : 4'd10;
`else
  assign nr_in = 4'd10;
`endif

  assign rk = bus.round_key;

  // Inverse round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    // byte (row r, col c) sits at index 4*c+r; row r rotates right by r
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    for (int b = 0; b < 16; b++) begin
      subbed[127-8*b -: 8] = inv_sbox(shifted[127-8*b -: 8]);
    end
    keyed = subbed ^ rk;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
    end
  end

  // Registered-state decode of the handshake and key index outputs
  always_comb begin
    bus.in_ready  = (fsm_q == StIdle);
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    case (fsm_q)
      StIdle:  bus.key_idx = nr_in;
      StRound: bus.key_idx = rnd_q;
      default: bus.key_idx = 4'd0;
    endcase
  end

  // FSM and round counter next state
  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = bus.in_data ^ rk;
          rnd_d   = nr_in - 4'd1;
          fsm_d   = StRound;
        end
      end
      StRound: begin
        state_d = mixed;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = StFinal;
      end
      StFinal: begin
        out_data_d  = keyed;
        out_valid_d = 1'b1;
        fsm_d       = StDone;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = StIdle;
        end
      end
    endcase
  end

  // State registers; reset discards any block in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= StIdle;
      rnd_q       <= 4'd0;
      state_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
